// File: rtl/prog_loader_defs.sv
// Shared loader definitions: FSM state encoding and frame/bus field widths.
package prog_loader_defs;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DAT_LO,
    DAT_HI,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;
  localparam int WCNT_W = 11;
  localparam int ADR_W  = 24;

endpackage

// File: rtl/wb_single_write.sv
// One Wishbone write transaction: holds cyc/stb/we from i_start until ack or
// until ACK_TIMEOUT consecutive un-acked cycles have elapsed.
module wb_single_write
  import prog_loader_defs::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADR_W-1:0]  i_adr,
  input  logic [WORD_W-1:0] i_dat,
  input  logic              i_ack,
  output logic              o_cyc,
  output logic              o_stb,
  output logic              o_we,
  output logic [ADR_W-1:0]  o_adr,
  output logic [WORD_W-1:0] o_dat,
  output logic              o_done,
  output logic              o_timeout
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic             r_busy;
  logic [TMO_W-1:0] r_ack_cnt;

  assign o_done    = r_busy & i_ack;
  // The edge that would bring the counter to ACK_TIMEOUT ends the transaction.
  assign o_timeout = r_busy & ~i_ack & (r_ack_cnt == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= 1'b0;
      r_ack_cnt <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_ack_cnt <= '0;
    end else if (o_done || o_timeout) begin
      r_busy    <= 1'b0;
      r_ack_cnt <= '0;
    end else if (r_busy) begin
      r_ack_cnt <= r_ack_cnt + 1'b1;
    end
  end

  assign o_cyc = r_busy;
  assign o_stb = r_busy;
  assign o_we  = r_busy;
  assign o_adr = i_adr;
  assign o_dat = i_dat;

endmodule

// File: rtl/prog_loader.sv
// Boot program loader: parses a byte stream (16-bit count, then LE words) and
// writes each word to consecutive Wishbone addresses while holding the CPU.
module prog_loader
  import prog_loader_defs::*;
#(
  parameter logic [ADR_W-1:0] BASE_ADR    = 24'h010000,
  parameter int               MAX_WORDS   = 1024,
  parameter int               ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byteData,
  input  logic              byteValid,
  output logic              byteReady,
  output logic [ADR_W-1:0]  wbAdrO,
  output logic [WORD_W-1:0] wbDatO,
  output logic              wbCycO,
  output logic              wbStbO,
  output logic              wbWeO,
  input  logic              wbAckI,
  input  logic              restart,
  output logic              holdCpu,
  output logic              done,
  output logic              error,
  output logic [WCNT_W-1:0] wordsWritten
);

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [BYTE_W-1:0]   r_lo;
  logic [WORD_W-1:0]   r_word;
  logic [WCNT_W-1:0]   r_words;

  logic                w_xfer;
  logic                w_start;
  logic                w_wr_done;
  logic                w_wr_tmo;
  logic [CNT_W-1:0]    w_cnt;
  logic [WCNT_W-1:0]   w_words_nxt;
  logic [ADR_W-1:0]    w_adr;

  assign byteReady    = r_state inside {CNT_LO, CNT_HI, DAT_LO, DAT_HI};
  assign done         = (r_state == DONE);
  assign error        = (r_state == ERROR);
  assign holdCpu      = (r_state != DONE);
  assign wordsWritten = r_words;

  assign w_xfer      = byteValid & byteReady;
  assign w_start     = w_xfer & (r_state == DAT_HI);
  assign w_cnt       = {byteData, r_count[BYTE_W-1:0]};
  assign w_words_nxt = r_words + 1'b1;
  assign w_adr       = BASE_ADR + ADR_W'(r_words);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CNT_LO;
      r_count <= '0;
      r_word  <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        CNT_LO: if (w_xfer) begin
          r_count <= CNT_W'(byteData);
          r_state <= CNT_HI;
        end
        CNT_HI: if (w_xfer) begin
          r_count <= w_cnt;
          if (w_cnt == '0)                       r_state <= DONE;
          else if (w_cnt > CNT_W'(MAX_WORDS))    r_state <= ERROR;
          else                                   r_state <= DAT_LO;
        end
        DAT_LO: if (w_xfer) r_state <= DAT_HI;
        DAT_HI: if (w_xfer) begin
          r_word  <= {byteData, r_lo};
          r_state <= WRITE;
        end
        WRITE: begin
          if (w_wr_done) begin
            r_words <= w_words_nxt;
            r_state <= (CNT_W'(w_words_nxt) == r_count) ? DONE : DAT_LO;
          end else if (w_wr_tmo) begin
            r_state <= ERROR;
          end
        end
        DONE, ERROR: if (restart) begin
          r_words <= '0;
          r_count <= '0;
          r_state <= CNT_LO;
        end
        default: r_state <= CNT_LO;
      endcase
    end
  end

  // Low data byte is only consumed after its matching high byte arrives.
  always_ff @(posedge clk) begin
    if (w_xfer && r_state == DAT_LO) r_lo <= byteData;
  end

  wb_single_write #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_adr     (w_adr),
    .i_dat     (r_word),
    .i_ack     (wbAckI),
    .o_cyc     (wbCycO),
    .o_stb     (wbStbO),
    .o_we      (wbWeO),
    .o_adr     (wbAdrO),
    .o_dat     (wbDatO),
    .o_done    (w_wr_done),
    .o_timeout (w_wr_tmo)
  );

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADR, default 24'h010000, Wishbone address of program word 0.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word count.
REQ-003 Parameter ACK_TIMEOUT, default 16, cycles allowed for wbAckI per write.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-006 byteData  in  8  incoming program byte.
REQ-007 byteValid  in  1  byteData valid.
REQ-008 byteReady  out  1  loader accepts a byte this cycle.
REQ-009 wbAdrO  out  24  Wishbone address.
REQ-010 wbDatO  out  16  Wishbone write data.
REQ-011 wbCycO, wbStbO, wbWeO  out  1 each  Wishbone cycle, strobe and write enable.
REQ-012 wbAckI  in  1  Wishbone acknowledge.
REQ-013 restart  in  1  one-cycle request to start a new load.
REQ-014 holdCpu  out  1  keeps the processor in reset while loading.
REQ-015 done  out  1  load completed.
REQ-016 error  out  1  load aborted.
REQ-017 wordsWritten  out  11  count of acknowledged writes.

Function
REQ-018 A byte is transferred only in a cycle with byteValid=1 and byteReady=1.
REQ-019 Frame format: count low byte, count high byte, then per word a low byte followed by a high byte.
REQ-020 States: CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, DONE, ERROR.
REQ-021 byteReady is 1 in states CNT_LO, CNT_HI, DAT_LO and DAT_HI, and 0 in all other states.
REQ-022 After a transfer in CNT_HI:
- count=0 -> DONE
- count>MAX_WORDS -> ERROR
- otherwise -> DAT_LO.
REQ-023 A transfer in DAT_HI latches the word and moves the FSM to WRITE in the following cycle.
REQ-024 In WRITE, wbCycO, wbStbO and wbWeO are 1, wbAdrO=BASE_ADR+wordsWritten (24-bit, wrap-around permitted), and wbDatO holds the assembled word.
REQ-025 Ack handling:
- wbAckI=1 at a rising edge in WRITE completes the write; the strobes deassert on that edge and wordsWritten increments.
- On completion, the FSM goes to DONE if wordsWritten equals count, else to DAT_LO.
REQ-026 Ack timeout:
- An ack counter clears on entry to WRITE and increments every WRITE cycle without ack.
- Reaching ACK_TIMEOUT -> ERROR, with the strobes deasserted on the same edge.
REQ-027 Strobes are never asserted outside WRITE, and the block never issues reads (wbWeO=1 whenever wbStbO=1).
REQ-028 Flags:
- DONE: done=1, holdCpu=0.
- ERROR: error=1, holdCpu=1.
- All other states: done=0, error=0, holdCpu=1.
REQ-029 restart=1 in DONE or ERROR clears wordsWritten, done and error, and enters CNT_LO; restart in any other state is ignored.
REQ-030 Extra bytes offered in DONE or ERROR are not accepted (byteReady=0).

Reset
REQ-031 Reset assertion immediately forces the following values:
- FSM: CNT_LO.
- Outputs: byteReady=1, wbCycO=0, wbStbO=0, wbWeO=0, wbAdrO=BASE_ADR, wbDatO=0.
- Flags: holdCpu=1, done=0, error=0, wordsWritten=0.
- Internal: count=0, ack counter=0.
REQ-032 Reset asserted during WRITE drops the strobes asynchronously, and the partial load is discarded.

Structure
REQ-033 FSM state encodings and the frame-format constants reside in a shared package or include file, prog_loader_defs.
REQ-034 The single-write Wishbone handshake, including the timeout counter, is one sub-module, wb_single_write; the byte assembly and FSM remain in prog_loader.

Verification
REQ-035 Stream 03 00 01 00 05 00 EF 00 with an ack one cycle after the strobe -> writes 0x0001@0x010000, 0x0005@0x010001, 0x00EF@0x010002; done=1, holdCpu=0, wordsWritten=3.
REQ-036 Stream 00 00 -> DONE with no Wishbone cycle and wordsWritten=0.
REQ-037 Count 0x0401 -> ERROR after the second byte; no write occurs and byteReady=0.
REQ-038 Slave that never acks -> strobes drop after 16 WRITE cycles; error=1, holdCpu=1, wordsWritten=0.
REQ-039 Reset asserted mid-WRITE -> strobes are 0 before the next clock edge; after release, the stream 01 00 34 12 writes 0x1234@0x010000.
REQ-040 byteValid toggling randomly plus restart pulsed mid-load -> frame content unaffected and restart ignored; a restart pulse after DONE reloads a second frame correctly.
